alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_sequencer.sv | 110 +++++++++++
 tb/tb_alu_sequencer.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM encodings shared by the byte-serial ALU sequencer.
package alu_pkg;

  localparam logic [5:0] OP_NOT = 6'b000001;
  localparam logic [5:0] OP_OR  = 6'b000010;
  localparam logic [5:0] OP_AND = 6'b000100;
  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_SUB = 6'b010000;
  localparam logic [5:0] OP_XOR = 6'b100000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic is_onehot(input logic [5:0] v);
    return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - drives an external 8-bit ALU byte by byte, LSB first, to build an NBYTES-wide result.
// Optional zero flag output is enabled with ALU_SEQ_ZFLAG_EN.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [5:0]            op,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  carry,
  output logic [7:0]            alu_a1,
  output logic [7:0]            alu_a2,
  output logic [5:0]            alu_op,
  output logic                  alu_e,
  output logic                  alu_cin,
  input  logic [7:0]            alu_out,
  input  logic                  alu_cout
`ifdef ALU_SEQ_ZFLAG_EN
  , output logic                zero
`endif
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [1:0]          state;
  logic [IW-1:0]       idx;
  logic [5:0]          op_q;
  logic [8*NBYTES-1:0] opa_q;
  logic [8*NBYTES-1:0] opb_q;
  logic                cin_q;
  logic [8*NBYTES-1:0] next_result;
  logic                exec;
  logic                arith;
  logic                last;

  assign exec  = (state == ST_EXEC);
  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign last  = (idx == IW'(NBYTES - 1));
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);

  // Carry chain only links bytes of ADD/SUB; byte 0 always starts clean.
  assign alu_e   = exec;
  assign alu_op  = exec ? op_q : 6'd0;
  assign alu_a1  = exec ? opa_q[8*int'(idx) +: 8] : 8'd0;
  assign alu_a2  = exec ? opb_q[8*int'(idx) +: 8] : 8'd0;
  assign alu_cin = exec && arith && (idx != '0) ? cin_q : 1'b0;

  always_comb begin
    next_result = result;
    next_result[8*int'(idx) +: 8] = alu_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      op_q   <= 6'd0;
      opa_q  <= '0;
      opb_q  <= '0;
      cin_q  <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
      zero   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_EXEC;
            // Malformed opcodes run with opflag 0 so the ALU produces zeros.
            op_q   <= is_onehot(op) ? op : 6'd0;
            opa_q  <= opa;
            opb_q  <= opb;
            idx    <= '0;
            cin_q  <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
            zero   <= 1'b0;
`endif
          end
        end
        ST_EXEC: begin
          result <= next_result;
          cin_q  <= alu_cout;
          idx    <= idx + 1'b1;
          if (last) begin
            state <= ST_DONE;
            carry <= arith ? alu_cout : 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
            zero  <= (next_result == '0);
`endif
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer with a behavioural 8-bit ALU beside it.
module tb_alu_sequencer;

  localparam int NBYTES = 2;
  localparam int W = 8 * NBYTES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [5:0]    op = 6'd0;
  logic [W-1:0]  opa = '0;
  logic [W-1:0]  opb = '0;
  logic          busy, done, carry;
  logic [W-1:0]  result;
  logic [7:0]    alu_a1, alu_a2, alu_out;
  logic [5:0]    alu_op;
  logic          alu_e, alu_cin, alu_cout;
`ifdef ALU_SEQ_ZFLAG_EN
  logic          zero;
`endif

  alu_sequencer #(.NBYTES(NBYTES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_op(alu_op), .alu_e(alu_e),
    .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout)
`ifdef ALU_SEQ_ZFLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  // External 8-bit ALU: cout is carry for ADD, borrow for SUB.
  always_comb begin
    logic [8:0] t;
    t = 9'd0;
    if (alu_e) begin
      case (alu_op)
        6'b000001: t = {1'b0, ~alu_a1};
        6'b000010: t = {1'b0, alu_a1 | alu_a2};
        6'b000100: t = {1'b0, alu_a1 & alu_a2};
        6'b001000: t = {1'b0, alu_a1} + {1'b0, alu_a2} + {8'd0, alu_cin};
        6'b010000: t = {1'b0, alu_a1} - {1'b0, alu_a2} - {8'd0, alu_cin};
        6'b100000: t = {1'b0, alu_a1 ^ alu_a2};
        default:   t = 9'd0;
      endcase
    end
    alu_out  = t[7:0];
    alu_cout = t[8];
  end

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Whole-word reference: arithmetic on the full operands, no byte slicing.
  function automatic exp_t model(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint full;
    full = longint'(1) << W;
    e.res = '0; e.c = 1'b0; e.acc = 0;
    if ($countones(o) == 1) begin
      case (o)
        6'b000001: e.res = ~a;
        6'b000010: e.res = a | b;
        6'b000100: e.res = a & b;
        6'b001000: begin
          e.res = W'((longint'(a) + longint'(b)) % full);
          e.c   = (longint'(a) + longint'(b)) >= full;
        end
        6'b010000: begin
          e.res = W'((longint'(a) - longint'(b) + full) % full);
          e.c   = a < b;
        end
        default:   e.res = a ^ b;
      endcase
    end
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [5:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input bit use_const, input logic [W-1:0] cres, input logic cc);
    exp_t e;
    wait_idle();
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    e = model(o, a, b);
    if (use_const) begin
      e.res = cres; e.c = cc; e.z = (cres == '0);
    end
    e.acc = cyc;
    if (push) exp_q.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_carry"}, carry, 0);
    check({tag, "_alu"}, {alu_e, alu_cin, alu_op, alu_a1, alu_a2}, 0);
`ifdef ALU_SEQ_ZFLAG_EN
    check({tag, "_zero"}, zero, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", result, e.res);
          check("carry", carry, e.c);
          check("done_latency", cyc - e.acc + 1, NBYTES + 1);
          check("busy_with_done", busy, 1);
`ifdef ALU_SEQ_ZFLAG_EN
          check("zero", zero, e.z);
`endif
        end
      end
      if (!busy) check("alu_quiet_outside_exec", {alu_e, alu_cin, alu_op, alu_a1, alu_a2}, 0);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    issue(6'b001000, 16'h00FF, 16'h0001, 1, 1, 16'h0100, 1'b0);
    issue(6'b001000, 16'hFFFF, 16'h0001, 1, 1, 16'h0000, 1'b1);
    issue(6'b010000, 16'h0000, 16'h0001, 1, 1, 16'hFFFF, 1'b1);
    issue(6'b010000, 16'h0100, 16'h0001, 1, 1, 16'h00FF, 1'b0);
    issue(6'b100000, 16'hA5F0, 16'hFF0F, 1, 1, 16'h5AFF, 1'b0);
    issue(6'h0C,     16'h1234, 16'h5678, 1, 1, 16'h0000, 1'b0);
    issue(6'h00,     16'hFFFF, 16'hFFFF, 1, 1, 16'h0000, 1'b0);
    issue(6'b000001, 16'h1234, 16'hFFFF, 1, 1, 16'hEDCB, 1'b0);
    drain();

    for (int i = 0; i < 40; i++) begin
      int sel;
      logic [5:0] o;
      sel = $urandom_range(0, 7);
      o = (sel < 6) ? 6'(1 << sel) : 6'($urandom);
      issue(o, W'($urandom), W'($urandom), 1, 0, '0, 1'b0);
    end
    drain();

    // Start raised mid-operation must be dropped; only the first result may appear.
    issue(6'b001000, 16'h1111, 16'h2222, 1, 1, 16'h3333, 1'b0);
    @(negedge clk);
    start = 1'b1; op = 6'b100000; opa = 16'hFFFF; opb = 16'h0F0F;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    repeat (6) @(negedge clk);

    // Reset during byte 1 abandons the operation without a done pulse.
    issue(6'b001000, 16'h7FFF, 16'h0001, 0, 0, '0, 1'b0);
    @(posedge clk);
    #1;
    check("exec_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_exec_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("no_done_after_reset", exp_q.size(), 0);

    issue(6'b010000, 16'h8000, 16'h0001, 1, 1, 16'h7FFF, 1'b0);
    drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
